// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port data memory between the core LSU (port 0)
//            and a debug/DMA master (port 1). At most one access is granted
//            per cycle. Read data, which arrives one cycle late, is routed
//            back to the requesting port. A per-port lock holds ownership
//            across multi-word sequences.
// Options  : DMEM_ARB_RR_EN - when defined, contention is resolved
//            round-robin; otherwise port 0 always wins.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic              mem_wr_select,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } own_e;

  own_e lock_own_q;
  own_e lock_own_d;
  own_e own_eff;
  logic rvalid0_q;
  logic rvalid0_d;
  logic rvalid1_q;
  logic rvalid1_d;
  logic gnt0;
  logic gnt1;
`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_q;
  logic rr_ptr_d;
`endif

  // Ownership as seen this cycle (an owner dropping lock releases at once),
  // then grant selection; nothing is granted while reset is asserted.
  always_comb begin
    own_eff = lock_own_q;
    if ((lock_own_q == OWN_P0) && !m0_lock) own_eff = OWN_NONE;
    if ((lock_own_q == OWN_P1) && !m1_lock) own_eff = OWN_NONE;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (own_eff)
        OWN_P0: gnt0 = m0_req;
        OWN_P1: gnt1 = m1_req;
        default: begin
          if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = ~rr_ptr_q;
            gnt1 = rr_ptr_q;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
      endcase
    end
  end

  // Next-state: lock capture, pending read returns and priority pointer.
  always_comb begin
    lock_own_d = own_eff;
    if (own_eff == OWN_NONE) begin
      if (gnt0 && m0_lock)      lock_own_d = OWN_P0;
      else if (gnt1 && m1_lock) lock_own_d = OWN_P1;
    end
    rvalid0_d = gnt0 & ~m0_we;
    rvalid1_d = gnt1 & ~m1_we;
`ifdef DMEM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (gnt0)      rr_ptr_d = 1'b1;
    else if (gnt1) rr_ptr_d = 1'b0;
`endif
  end

  // State registers; reset drops any in-flight read response and the lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_own_q <= OWN_NONE;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      lock_own_q <= lock_own_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Memory drive from the granted port; idle bus is all zeros.
  always_comb begin
    mem_we        = 1'b0;
    mem_wr_select = 1'b0;
    mem_a         = '0;
    mem_wd        = '0;
    if (gnt0) begin
      mem_we        = m0_we;
      mem_wr_select = m0_we;
      mem_a         = m0_addr;
      mem_wd        = m0_wdata;
    end else if (gnt1) begin
      mem_we        = m1_we;
      mem_wr_select = m1_we;
      mem_a         = m1_addr;
      mem_wd        = m1_wdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rvalid0_q ? mem_rd : '0;
  assign m1_rdata  = rvalid1_q ? mem_rd : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios plus
//            randomized traffic compared against a transaction-level model.
//            Honors DMEM_ARB_RR_EN to match the build under test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m1_req, m1_we, m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_we, mem_wr_select;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_wr_select(mem_wr_select), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: write at the edge, registered read data.
  logic [DATA_W-1:0] tb_mem [256];
  logic              mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
    end else if (mem_we) begin
      tb_mem[mem_a[7:0]] <= mem_wd;
    end
    mem_rd <= tb_mem[mem_a[7:0]];
  end

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: owner (-1 none), contention pointer,
  // expected read returns and a shadow copy of memory contents.
  int                mdl_own = -1;
  bit                mdl_ptr = 1'b0;
  bit                exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  logic [DATA_W-1:0] exp_rd0 = '0, exp_rd1 = '0;
  logic [DATA_W-1:0] ref_mem [256];

  logic              obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [DATA_W-1:0] obs_rd0, obs_rd1;

  task automatic mdl_arb(output bit g0, output bit g1, output int eff);
    int winner;
    eff = mdl_own;
    if ((mdl_own == 0 && !m0_lock) || (mdl_own == 1 && !m1_lock)) eff = -1;
    winner = -1;
    if (reset) begin
      if (eff == 0)               winner = m0_req ? 0 : -1;
      else if (eff == 1)          winner = m1_req ? 1 : -1;
      else if (m0_req && m1_req)  winner = (RR_BUILD && mdl_ptr) ? 1 : 0;
      else if (m0_req)            winner = 0;
      else if (m1_req)            winner = 1;
    end
    g0 = (winner == 0);
    g1 = (winner == 1);
  endtask

  // One clock: drive at negedge, check all outputs, optionally assert reset
  // just before the edge, then advance the model across the rising edge.
  task automatic cycle(input bit rst_v, input bit kill,
                       input bit r0, input bit w0, input bit l0,
                       input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input bit r1, input bit w1, input bit l1,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    bit g0, g1;
    int eff;
    logic              e_we;
    logic [ADDR_W-1:0] e_a;
    logic [DATA_W-1:0] e_wd;
    @(negedge clk);
    reset = rst_v;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
    mdl_arb(g0, g1, eff);
    e_we = 1'b0; e_a = '0; e_wd = '0;
    if (g0)      begin e_we = w0; e_a = a0; e_wd = d0; end
    else if (g1) begin e_we = w1; e_a = a1; e_wd = d1; end
    chk("m0_gnt", m0_gnt, g0);
    chk("m1_gnt", m1_gnt, g1);
    chk("mem_we", mem_we, e_we);
    chk("mem_wr_select", mem_wr_select, e_we);
    chk("mem_a", mem_a, e_a);
    chk("mem_wd", mem_wd, e_wd);
    chk("m0_rvalid", m0_rvalid, reset && exp_rv0);
    chk("m1_rvalid", m1_rvalid, reset && exp_rv1);
    chk("m0_rdata", m0_rdata, (reset && exp_rv0) ? exp_rd0 : '0);
    chk("m1_rdata", m1_rdata, (reset && exp_rv1) ? exp_rd1 : '0);
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_rd1 = m1_rdata;
    if (kill) reset = 1'b0;
    @(posedge clk);
    if (!reset) begin
      mdl_own = -1; mdl_ptr = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    end else begin
      exp_rv0 = g0 && !w0; exp_rd0 = ref_mem[a0[7:0]];
      exp_rv1 = g1 && !w1; exp_rd1 = ref_mem[a1[7:0]];
      if (g0 && w0) ref_mem[a0[7:0]] = d0;
      if (g1 && w1) ref_mem[a1[7:0]] = d1;
      mdl_own = eff;
      if (mdl_own == -1) begin
        if (g0 && l0)      mdl_own = 0;
        else if (g1 && l1) mdl_own = 1;
      end
      if (g0)      mdl_ptr = 1'b1;
      else if (g1) mdl_ptr = 1'b0;
    end
  endtask

  task automatic idle(input bit rst_v);
    cycle(rst_v, 1'b0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [5:0] gpat;
    bit         m0_any;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;

    // Held in reset with both requesting: everything quiet.
    cycle(0, 0, 1, 0, 0, 20'h1, '0, 1, 0, 0, 20'h2, '0);
    cycle(0, 0, 1, 0, 0, 20'h1, '0, 1, 0, 0, 20'h2, '0);
    // First cycle out of reset goes to port 0.
    cycle(1, 0, 1, 0, 0, 20'h1, '0, 1, 0, 0, 20'h2, '0);
    chk("rst_release_gnt0", obs_g0, 1'b1);
    idle(1);

    // Single port write then read back.
    cycle(1, 0, 1, 1, 0, 20'h10, 32'hDEADBEEF, 0, 0, 0, '0, '0);
    cycle(1, 0, 1, 0, 0, 20'h10, '0, 0, 0, 0, '0, '0);
    idle(1);
    chk("single_rd_data", obs_rd0, 32'hDEADBEEF);
    chk("single_rvalid1", obs_rv1, 1'b0);

    // Lone port 1 write so that the pointer favours port 0 next.
    cycle(1, 0, 0, 0, 0, '0, '0, 1, 1, 0, 20'h40, 32'h0000_1234);
    gpat = '0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 1, 0, 0, 20'h1, '0, 1, 0, 0, 20'h2, '0);
      gpat[i] = obs_g1;
    end
    idle(1);
    chk("contention_pattern", gpat, RR_BUILD ? 6'b101010 : 6'b000000);

    // Port 1 takes the lock, holds it (req sometimes low) while port 0 waits.
    cycle(1, 0, 0, 0, 0, '0, '0, 1, 1, 1, 20'h20, 32'hCAFE_0001);
    m0_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 0, 0, 20'h5, '0, (i != 1), 1, 1, 20'h21 + i[ADDR_W-1:0], 32'hCAFE_0010 + i);
      m0_any |= obs_g0;
    end
    chk("lock_blocks_m0", m0_any, 1'b0);
    cycle(1, 0, 1, 0, 0, 20'h5, '0, 0, 0, 0, '0, '0);
    chk("lock_release_gnt0", obs_g0, 1'b1);
    idle(1);

    // Reset asserted between a granted read and its return.
    cycle(1, 1, 1, 0, 0, 20'h10, '0, 0, 0, 0, '0, '0);
    idle(0);
    idle(1);
    chk("no_rvalid_after_rst", obs_rv0, 1'b0);

    // Write by one port, immediate read of the same word by the other.
    cycle(1, 0, 1, 1, 0, 20'h30, 32'hA5A5_5A5A, 0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, 0, '0, '0, 1, 0, 0, 20'h30, '0);
    idle(1);
    chk("wr_then_rd_other", obs_rd1, 32'hA5A5_5A5A);

    // Randomized traffic with sticky locks and rare resets.
    for (int i = 0; i < 600; i++) begin
      bit rv, k;
      rv = ($urandom_range(0, 79) != 0);
      k  = rv && ($urandom_range(0, 99) == 0);
      cycle(rv, k,
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
            ADDR_W'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
            ADDR_W'($urandom_range(0, 15)), $urandom);
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
